// File: rtl/spi_target_pkg.sv
// Shared constants and state encoding for the SPI register-file responder.
package spi_target_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  // Byte shifted out whenever nothing meaningful is being returned.
  localparam logic [7:0] IDLE_FILL  = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_SDATA,
    S_IGNORE
  } state_t;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, with optional
// rise/fall detection on the synchronized value.
module spi_sync #(
  parameter bit EDGE    = 1'b1,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;

  // Bring the pin into the clk domain through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= {2{RST_VAL}};
    else        sync <= {sync[0], d};
  end

  assign q = sync[1];

  generate
    if (EDGE) begin : g_edge
      logic prev;

      // Remember the previous synchronized level for edge detection.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= RST_VAL;
        else        prev <= sync[1];
      end

      assign rise = sync[1] & ~prev;
      assign fall = ~sync[1] & prev;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_target.sv
// SPI responder: command / address / data frames against a small register
// file with auto-increment, plus a status byte and a write strobe.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          SCK,
  input  logic          nSS,
  input  logic          MOSI,
  output logic          MISO,
  output logic          MISO_OE,
  input  logic [7:0]    STATUS,
  output logic          WR_STB,
  output logic [AW-1:0] WR_ADDR,
  output logic [7:0]    WR_DATA
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic sck_rise, sck_fall, sck_q;
  logic nss_rise, nss_fall, nss_q;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  state_t        state, state_next;
  logic [2:0]    bitcnt;
  logic [6:0]    rx_shift;
  logic [7:0]    tx_shift, tx_next;
  logic [AW-1:0] ptr;
  logic          byte_seen, is_read;
  logic [7:0]    mem [DEPTH];

  logic          selected, byte_done, wr_en;
  logic [7:0]    rx_byte;
  logic [AW-1:0] rx_addr, ptr_inc;

  // SCK idles either level; a spurious edge after reset is ignored while idle.
  spi_sync #(.EDGE(1'b1), .RST_VAL(1'b0)) u_sync_sck (
    .clk(CLK), .rst_n(nRESET), .d(SCK), .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  // nSS resets "low" so a select still held across reset produces no falling
  // edge: the block waits until nSS is seen high and then falls again.
  spi_sync #(.EDGE(1'b1), .RST_VAL(1'b0)) u_sync_nss (
    .clk(CLK), .rst_n(nRESET), .d(nSS), .q(nss_q), .rise(nss_rise), .fall(nss_fall)
  );

  spi_sync #(.EDGE(1'b0), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(CLK), .rst_n(nRESET), .d(MOSI), .q(mosi_q),
    .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  assign selected  = (state != S_IDLE);
  assign byte_done = selected && sck_rise && (bitcnt == 3'd7);
  assign rx_byte   = {rx_shift, mosi_q};
  assign rx_addr   = rx_byte[AW-1:0];
  assign ptr_inc   = ptr + PTR_ONE;
  assign wr_en     = byte_done && (state == S_WDATA);

  assign MISO    = tx_shift[7];
  assign MISO_OE = selected;

  // Frame phase register.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= S_IDLE;
    else         state <= state_next;
  end

  // Phase sequencing: nSS edges override, otherwise advance per completed byte.
  always_comb begin
    state_next = state;
    if (nss_rise) begin
      state_next = S_IDLE;
    end else if (nss_fall) begin
      state_next = S_CMD;
    end else if (byte_done) begin
      case (state)
        S_CMD: begin
          if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) state_next = S_ADDR;
          else if (rx_byte == CMD_STATUS)                  state_next = S_SDATA;
          else                                             state_next = S_IGNORE;
        end
        S_ADDR:  state_next = is_read ? S_RDATA : S_WDATA;
        default: state_next = state;
      endcase
    end
  end

  // Bit shifting, pointer, read prefetch and write strobe.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bitcnt    <= 3'd0;
      rx_shift  <= 7'd0;
      tx_shift  <= IDLE_FILL;
      tx_next   <= IDLE_FILL;
      ptr       <= '0;
      byte_seen <= 1'b0;
      is_read   <= 1'b0;
      WR_STB    <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= 8'h00;
    end else begin
      WR_STB <= 1'b0;
      if (nss_fall) begin
        tx_shift  <= IDLE_FILL;
        tx_next   <= IDLE_FILL;
        bitcnt    <= 3'd0;
        byte_seen <= 1'b0;
      end else if (selected) begin
        if (sck_rise) begin
          rx_shift <= rx_byte[6:0];
          bitcnt   <= bitcnt + 3'd1;
        end
        if (byte_done) begin
          byte_seen <= 1'b1;
          case (state)
            S_CMD: begin
              is_read <= (rx_byte == CMD_READ);
              tx_next <= (rx_byte == CMD_STATUS) ? STATUS : IDLE_FILL;
            end
            S_ADDR: begin
              ptr     <= rx_addr;
              tx_next <= is_read ? mem[rx_addr] : IDLE_FILL;
            end
            S_WDATA: begin
              WR_STB  <= 1'b1;
              WR_ADDR <= ptr;
              WR_DATA <= rx_byte;
              ptr     <= ptr_inc;
            end
            S_RDATA: begin
              ptr     <= ptr_inc;
              tx_next <= mem[ptr_inc];
            end
            S_SDATA: tx_next <= STATUS;
            default: tx_next <= IDLE_FILL;
          endcase
        end
        // The first falling edge of a mode-3 frame (no byte yet) leaves tx_shift alone.
        if (sck_fall) begin
          if (bitcnt != 3'd0)  tx_shift <= {tx_shift[6:0], 1'b1};
          else if (byte_seen)  tx_shift <= tx_next;
        end
        // A completing byte on this same cycle has already been handled above.
        if (nss_rise) bitcnt <= 3'd0;
      end
    end
  end

  // Register file; only whole data bytes of a write frame land here.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (wr_en) begin
      mem[ptr] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: drives SPI frames in mode 0 and mode 3
// and scores MISO bytes and write strobes against expected queues.
module tb_spi_target;

  localparam int AW   = 4;
  localparam int HALF = 80;   // SCK half period = 8 CLK

  logic          CLK = 1'b0;
  logic          nRESET = 1'b0;
  logic          SCK = 1'b0;
  logic          nSS = 1'b1;
  logic          MOSI = 1'b0;
  logic [7:0]    STATUS = 8'h00;
  logic          MISO, MISO_OE, WR_STB;
  logic [AW-1:0] WR_ADDR;
  logic [7:0]    WR_DATA;

  logic          mode3 = 1'b0;
  logic [7:0]    rq [$];
  logic [11:0]   wq [$];
  int            checks = 0;
  int            errors = 0;

  spi_target #(.AW(AW)) dut (
    .CLK(CLK), .nRESET(nRESET), .SCK(SCK), .nSS(nSS), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .STATUS(STATUS),
    .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every strobe must match the oldest pending expected write.
  always @(negedge CLK) begin
    if (WR_STB) begin
      if (wq.size() == 0) begin
        check("wr_spurious", {31'd0, WR_STB}, 32'd0);
      end else begin
        logic [11:0] exp;
        exp = wq.pop_front();
        check("wr_strobe", {20'd0, WR_ADDR, WR_DATA}, {20'd0, exp});
        $display("write addr=%0h data=%02h expected addr=%0h data=%02h",
                 WR_ADDR, WR_DATA, exp[11:8], exp[7:0]);
      end
    end
  end

  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (mode3) SCK = 1'b0;
      MOSI = b[7-i];
      #(HALF);
      SCK = 1'b1;
      got = {got[6:0], MISO};
      #(HALF);
      if (!mode3) SCK = 1'b0;
    end
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input logic [7:0] exp_miso);
    logic [7:0] got, exp;
    rq.push_back(exp_miso);
    xfer(b, 8, got);
    exp = rq.pop_front();
    check(tag, {24'd0, got}, {24'd0, exp});
    $display("%s mosi=%02h miso=%02h expected=%02h", tag, b, got, exp);
  endtask

  task automatic begin_frame(input logic m3);
    mode3 = m3;
    SCK   = m3;
    repeat (8) @(negedge CLK);
    nSS = 1'b0;
    repeat (6) @(negedge CLK);
    check("oe_on", {31'd0, MISO_OE}, 32'd1);
  endtask

  task automatic end_frame();
    #(HALF);
    nSS = 1'b1;
    repeat (8) @(negedge CLK);
    check("oe_off", {31'd0, MISO_OE}, 32'd0);
    check("wr_pending", wq.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},    {31'd0, MISO},    32'd1);
    check({tag, "_oe"},      {31'd0, MISO_OE}, 32'd0);
    check({tag, "_stb"},     {31'd0, WR_STB},  32'd0);
    check({tag, "_waddr"},   {28'd0, WR_ADDR}, 32'd0);
    check({tag, "_wdata"},   {24'd0, WR_DATA}, 32'd0);
  endtask

  initial begin
    logic [7:0] junk;
    repeat (4) @(negedge CLK);
    check_reset_outputs("reset");
    nRESET = 1'b1;
    repeat (4) @(negedge CLK);

    // Mode 0 write with auto-increment.
    begin_frame(1'b0);
    wq.push_back({4'h5, 8'hA1});
    wq.push_back({4'h6, 8'hB2});
    send_byte("w_cmd",  8'h02, 8'hFF);
    send_byte("w_addr", 8'h05, 8'hFF);
    send_byte("w_d0",   8'hA1, 8'hFF);
    send_byte("w_d1",   8'hB2, 8'hFF);
    end_frame();

    // Mode 3 read back.
    begin_frame(1'b1);
    send_byte("r3_cmd",  8'h03, 8'hFF);
    send_byte("r3_addr", 8'h05, 8'hFF);
    send_byte("r3_d0",   8'h00, 8'hA1);
    send_byte("r3_d1",   8'h00, 8'hB2);
    end_frame();

    // Pointer wrap on write and on read.
    begin_frame(1'b0);
    wq.push_back({4'hF, 8'h11});
    wq.push_back({4'h0, 8'h22});
    send_byte("ww_cmd",  8'h02, 8'hFF);
    send_byte("ww_addr", 8'h0F, 8'hFF);
    send_byte("ww_d0",   8'h11, 8'hFF);
    send_byte("ww_d1",   8'h22, 8'hFF);
    end_frame();
    begin_frame(1'b0);
    send_byte("rw_cmd",  8'h03, 8'hFF);
    send_byte("rw_addr", 8'h0F, 8'hFF);
    send_byte("rw_d0",   8'h00, 8'h11);
    send_byte("rw_d1",   8'h00, 8'h22);
    end_frame();

    // Status byte, steady.
    STATUS = 8'h5A;
    begin_frame(1'b0);
    send_byte("st_cmd", 8'h05, 8'hFF);
    send_byte("st_d0",  8'h00, 8'h5A);
    send_byte("st_d1",  8'h00, 8'h5A);
    end_frame();

    // Status byte changing mid-frame shows up on the following byte.
    begin_frame(1'b1);
    send_byte("sc_cmd", 8'h05, 8'hFF);
    STATUS = 8'h3C;
    send_byte("sc_d0",  8'h00, 8'h5A);
    send_byte("sc_d1",  8'h00, 8'h3C);
    end_frame();

    // Seed mem[3], then abort a write after 5 data bits.
    begin_frame(1'b0);
    wq.push_back({4'h3, 8'h77});
    send_byte("s_cmd",  8'h02, 8'hFF);
    send_byte("s_addr", 8'h03, 8'hFF);
    send_byte("s_d0",   8'h77, 8'hFF);
    end_frame();
    begin_frame(1'b0);
    send_byte("p_cmd",  8'h02, 8'hFF);
    send_byte("p_addr", 8'h03, 8'hFF);
    xfer(8'h55, 5, junk);
    end_frame();
    begin_frame(1'b0);
    send_byte("pr_cmd",  8'h03, 8'hFF);
    send_byte("pr_addr", 8'h03, 8'hFF);
    send_byte("pr_d0",   8'h00, 8'h77);
    end_frame();

    // Reset in the middle of a write data byte.
    begin_frame(1'b0);
    send_byte("rst_cmd",  8'h02, 8'hFF);
    send_byte("rst_addr", 8'h07, 8'hFF);
    xfer(8'h99, 4, junk);
    nRESET = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("midrst");
    nRESET = 1'b1;
    repeat (4) @(negedge CLK);
    xfer(8'h90, 4, junk);
    check("oe_after_rst", {31'd0, MISO_OE}, 32'd0);
    end_frame();
    begin_frame(1'b0);
    send_byte("ar_cmd",  8'h03, 8'hFF);
    send_byte("ar_addr", 8'h07, 8'hFF);
    send_byte("ar_d0",   8'h00, 8'h00);
    end_frame();
    begin_frame(1'b1);
    send_byte("ac_cmd",  8'h03, 8'hFF);
    send_byte("ac_addr", 8'h05, 8'hFF);
    send_byte("ac_d0",   8'h00, 8'h00);
    end_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI responder that sits at the far end of the expansion board's bit-banged SPI master (SCK/MOSI/nSS/MISO), used on peripheral boards and as the bench target for the master. It oversamples the SPI pins in its own clock domain and decodes a three-phase frame: command, address, then data. It serves a small register file with auto-increment, plus a status byte. Local logic sees every register write through a one-cycle strobe.

## Interface
- AW, 4, register file address width (2^AW bytes); address byte uses its low AW bits.
- CLK  in  1  system clock; must be ≥ 8× SCK frequency.
- nRESET  in  1  asynchronous, active-low reset.
- SCK  in  1  SPI clock, asynchronous to CLK, mode 0 or mode 3.
- nSS  in  1  active-low select, asynchronous.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- MISO_OE  out  1  high while selected; the board tristates MISO otherwise.
- STATUS  in  8  byte returned by the status command.
- WR_STB  out  1  one-CLK pulse per completed write byte.
- WR_ADDR  out  AW  register address of the write.
- WR_DATA  out  8  written byte.

## Operation
- SCK, nSS and MOSI each pass through a 2-flop synchronizer. Edge detect runs on the synchronized SCK and nSS.
- MOSI is sampled on each SCK rising edge into rx_shift. bitcnt (3 bits) counts sampled bits; the 8th rising edge completes a byte.
- MISO is driven from tx_shift[7]:
  - nSS falling: tx_shift is loaded with 0xFF.
  - SCK falling with bitcnt≠0: tx_shift shifts left, filling with 1.
  - SCK falling with bitcnt=0 and at least one byte already completed in this frame: tx_shift is loaded with tx_next.
  - SCK falling with bitcnt=0 and no byte completed yet: no change. This is the mode-3 leading edge.
- State machine: IDLE → CMD (nSS low) → ADDR → WDATA / RDATA / SDATA / IGNORE.
  - CMD byte: 0x02 selects write; 0x03 selects read; 0x05 goes to SDATA; any other value goes to IGNORE for the rest of the frame.
  - ADDR byte, read or write: ptr ← rx[AW-1:0]. For a read, tx_next ← mem[ptr] in the same cycle.
  - WDATA, each completed byte: mem[ptr] ← rx, then WR_STB=1, WR_ADDR=ptr, WR_DATA=rx, then ptr ← ptr+1.
  - RDATA, each completed byte: ptr ← ptr+1, then tx_next ← mem[ptr+1].
  - SDATA: tx_next ← STATUS, sampled at the SCK-rising edge that completes each byte, including the command byte itself.
  - IGNORE, and CMD/ADDR phases of non-read commands: tx_next = 0xFF.
- ptr wraps from 2^AW−1 to 0 modulo 2^AW, with no error.
- nSS rising in any state: go to IDLE, clear bitcnt, discard any partial byte (no write, no strobe), set MISO_OE=0.
- nSS rising on the same CLK as a byte-completing SCK edge: the byte completes first, then the frame ends.
- Reset values: state IDLE, bitcnt 0, ptr 0, all mem bytes 0x00, tx_shift 0xFF, MISO 1, MISO_OE 0, WR_STB 0, WR_ADDR 0, WR_DATA 0x00. Reset mid-frame aborts the frame with no write. After reset release, the block waits for a fresh nSS falling edge.

## Timing
- Input pin → synchronized edge event: 3 CLK.
- SCK falling → MISO updated: ≤ 4 CLK. The SCK half-period must be ≥ 4 CLK; the Gigatron master is far slower.
- SCK rising completing a byte → WR_STB high: the next CLK, for exactly 1 CLK.
- Read prefetch completes 1 CLK after the byte-completing edge, well before the next SCK falling edge.
- nSS falling → MISO_OE high: 3 CLK.

## Structure
- spi_target_pkg holds:
  - command constants CMD_WRITE=0x02, CMD_READ=0x03, CMD_STATUS=0x05;
  - the IDLE/CMD/ADDR/WDATA/RDATA/SDATA/IGNORE state encoding;
  - the idle fill byte 0xFF.
- One sub-module, spi_sync: 2-flop synchronizer plus rise/fall detector. Instantiated for SCK and nSS, and for MOSI without the edge detector.
- Register file: flops, 2^AW × 8.

## Test plan
- Mode 0, frame 02 05 A1 B2: mem[5]=0xA1 and mem[6]=0xB2; two WR_STB pulses with (5,A1) and (6,B2).
- Mode 3, frame 03 05 00 00 after the previous write: MISO returns FF FF A1 B2.
- AW=4, frame 02 0F 11 22 then read 03 0F xx xx: ptr wraps, so mem[15]=0x11 and mem[0]=0x22; the read returns 11 22.
- STATUS=0x5A, frame 05 00 00: MISO returns FF 5A 5A. Change STATUS to 0x3C mid-frame → the next full byte returns 3C.
- Frame 02 03 then 5 bits, then nSS high: no WR_STB, mem[3] unchanged. The next frame 03 03 00 decodes cleanly.
- nRESET low during the data byte of 02 07 xx: no write; outputs at reset values; a later 03 07 00 returns 00.
